// File: rtl/latch_write_sequencer.sv
// Round-robin sequencer that shares one level-sensitive D-latch bank among NREQ
// requesters, walking each write through setup / enable / hold so D never moves while EN is high.
module latch_write_sequencer #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  input  logic [WIDTH-1:0]        latch_q,
  output logic [WIDTH-1:0]        latch_d,
  output logic                    latch_en,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic                    mismatch,
  output logic [2:0]              state_dbg
);

  // Handshake: req is a level; it is sampled only in IDLE, data is captured at grant,
  // and ack pulses for one cycle in DONE. A requester drops req on the edge that sees ack.

  localparam int MAXC = (SETUP_CYC > EN_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
  localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam int PW = $clog2(NREQ);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [NREQ-1:0] ONE    = NREQ'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   cand;
  logic [WIDTH-1:0] pick_data;

  assign state_dbg = state;

  // Scan from the highest offset down so the nearest request at/after ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == pick_idx) pick_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      gidx     <= '0;
      latch_d  <= '0;
      latch_en <= 1'b0;
      grant    <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          latch_en <= 1'b0;
          if (pick_valid) begin
            gidx    <= pick_idx;
            grant   <= ONE << pick_idx;
            latch_d <= pick_data;
            cnt     <= SETUP_LD;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt      <= EN_LD;
            latch_en <= 1'b1;
            state    <= ENABLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ENABLE: begin
          if (cnt == '0) begin
            cnt      <= HOLD_LD;
            latch_en <= 1'b0;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            ack   <= grant;
            state <= DONE;
            // Readback check on the final hold cycle; sticky until reset.
            if (latch_q != latch_d) mismatch <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state <= IDLE;
        end
        default: begin
          latch_en <= 1'b0;
          grant    <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer: one default instance and one with
// stretched timing (2/3/2), each driving a behavioural latch model.
module tb_latch_write_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  req1 = '0, req2 = '0;
  logic [31:0] wdata1 = '0, wdata2 = '0;
  logic [7:0]  q1, q2, latch_d1, latch_d2;
  logic        latch_en1, latch_en2;
  logic [3:0]  grant1, grant2, ack1, ack2;
  logic        busy1, busy2, mismatch1, mismatch2;
  logic [2:0]  state_dbg1, state_dbg2;

  logic [7:0]  lat1 = '0, lat2 = '0;
  bit          stuck1 = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  latch_write_sequencer dut1 (
    .clk(clk), .rst(rst), .req(req1), .wdata(wdata1), .latch_q(q1),
    .latch_d(latch_d1), .latch_en(latch_en1), .grant(grant1), .ack(ack1),
    .busy(busy1), .mismatch(mismatch1), .state_dbg(state_dbg1)
  );

  latch_write_sequencer #(.SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .wdata(wdata2), .latch_q(q2),
    .latch_d(latch_d2), .latch_en(latch_en2), .grant(grant2), .ack(ack2),
    .busy(busy2), .mismatch(mismatch2), .state_dbg(state_dbg2)
  );

  // Transparent-high latch models; dut1's can be forced stuck-at-0 on its output.
  always @(latch_en1 or latch_d1) if (latch_en1) lat1 = latch_d1;
  always @(latch_en2 or latch_d2) if (latch_en2) lat2 = latch_d2;
  assign q1 = stuck1 ? 8'h00 : lat1;
  assign q2 = lat2;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_g [7];
  logic [7:0] exp_dat;
  int         en_cnt;

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

    // Reset state
    step(2);
    rst = 1'b0;
    chk("rst_latch_d", latch_d1, 8'h00);
    chk("rst_latch_en", latch_en1, 1'b0);
    chk("rst_grant", grant1, 4'b0000);
    chk("rst_ack", ack1, 4'b0000);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_mismatch", mismatch1, 1'b0);
    chk("rst_state", state_dbg1, 3'd0);

    // Single write with default timing
    req1 = 4'b0001;
    wdata1[7:0] = 8'hA5;
    step();
    chk("w1_grant_t1", grant1, 4'b0001);
    chk("w1_d_t1", latch_d1, 8'hA5);
    chk("w1_en_t1", latch_en1, 1'b0);
    chk("w1_busy_t1", busy1, 1'b1);
    step();
    chk("w1_en_t2", latch_en1, 1'b1);
    step();
    chk("w1_en_t3", latch_en1, 1'b1);
    chk("w1_ack_t3", ack1, 4'b0000);
    step();
    chk("w1_en_t4", latch_en1, 1'b0);
    chk("w1_ack_t4", ack1, 4'b0000);
    step();
    chk("w1_ack_t5", ack1, 4'b0001);
    chk("w1_mismatch", mismatch1, 1'b0);
    chk("w1_latch", lat1, 8'hA5);
    req1 = 4'b0000;
    step();
    chk("w1_ack_t6", ack1, 4'b0000);
    chk("w1_busy_t6", busy1, 1'b0);
    chk("w1_grant_t6", grant1, 4'b0000);

    // Contention: all requesting from pointer 0, then 1010 from pointer 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    wdata1 = 32'h44332211;
    req1 = 4'b1111;
    step();
    for (int n = 0; n < 7; n++) begin
      exp_dat = 8'h00;
      for (int b = 0; b < 4; b++) if (exp_g[n][b]) exp_dat = 8'h11 * 8'(b + 1);
      chk($sformatf("rr_grant_%0d", n), grant1, exp_g[n]);
      chk($sformatf("rr_data_%0d", n), latch_d1, exp_dat);
      step(4);
      chk($sformatf("rr_ack_%0d", n), ack1, exp_g[n]);
      if (n == 4) req1 = 4'b1010;
      step(2);
    end
    req1 = 4'b0000;
    chk("rr_mismatch", mismatch1, 1'b0);

    // Setup/hold invariant on the stretched-timing instance
    req2 = 4'b0001;
    wdata2[7:0] = 8'h3C;
    step();
    chk("inv_grant", grant2, 4'b0001);
    chk("inv_d_grant", latch_d2, 8'h3C);
    req2 = 4'b0000;
    en_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      wdata2[7:0] = wdata2[7:0] ^ 8'hFF;
      step();
      if (latch_en2) en_cnt++;
      chk($sformatf("inv_d_%0d", i), latch_d2, 8'h3C);
      chk($sformatf("inv_en_%0d", i), latch_en2, (i >= 2 && i <= 4) ? 1'b1 : 1'b0);
      chk($sformatf("inv_ack_%0d", i), ack2, (i == 7) ? 4'b0001 : 4'b0000);
    end
    chk("inv_en_count", en_cnt, 3);
    chk("inv_latch", lat2, 8'h3C);
    chk("inv_mismatch", mismatch2, 1'b0);

    // Mismatch detect with stuck-at-0 latch, then stays sticky over a good write
    step(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    stuck1 = 1'b1;
    wdata1 = 32'h000000FF;
    req1 = 4'b0001;
    step();
    req1 = 4'b0000;
    step(3);
    chk("mm_before", mismatch1, 1'b0);
    step();
    chk("mm_ack", ack1, 4'b0001);
    chk("mm_set", mismatch1, 1'b1);
    stuck1 = 1'b0;
    step();
    wdata1 = 32'h00005A00;
    req1 = 4'b0010;
    step();
    req1 = 4'b0000;
    chk("mm_good_grant", grant1, 4'b0010);
    step(4);
    chk("mm_good_ack", ack1, 4'b0010);
    chk("mm_good_latch", lat1, 8'h5A);
    chk("mm_sticky", mismatch1, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mm_cleared", mismatch1, 1'b0);

    // Reset during ENABLE
    wdata1 = 32'h00006677;
    req1 = 4'b0001;
    step(2);
    chk("rm_en_before", latch_en1, 1'b1);
    rst = 1'b1;
    step();
    chk("rm_en", latch_en1, 1'b0);
    chk("rm_grant", grant1, 4'b0000);
    chk("rm_busy", busy1, 1'b0);
    chk("rm_d", latch_d1, 8'h00);
    chk("rm_ack", ack1, 4'b0000);
    chk("rm_state", state_dbg1, 3'd0);
    rst = 1'b0;
    req1 = 4'b0110;
    step();
    chk("rm_next_grant", grant1, 4'b0010);
    chk("rm_next_d", latch_d1, 8'h66);
    req1 = 4'b0000;
    step(4);
    chk("rm_next_ack", ack1, 4'b0010);
    step();

    // Early req drop during SETUP
    wdata1 = 32'h00C30000;
    req1 = 4'b0100;
    step();
    chk("ed_grant", grant1, 4'b0100);
    req1 = 4'b0000;
    step(3);
    chk("ed_ack_early", ack1, 4'b0000);
    step();
    chk("ed_ack", ack1, 4'b0100);
    chk("ed_latch", lat1, 8'hC3);
    step();
    chk("ed_busy", busy1, 1'b0);
    chk("ed_grant_idle", grant1, 4'b0000);
    step();
    chk("ed_stay_idle", busy1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
